// File: rtl/alu_decode_stage_pkg.sv
// Decode result record and immediate/select helpers for the ALU decode stage.
`include "alu_definitions.vh"
`include "rv32i_opcodes.vh"

package alu_decode_stage_pkg;

    typedef struct packed {
        logic [3:0]  alusel;
        logic [31:0] data1;
        logic [31:0] data2;
        logic [4:0]  rd;
        logic        regwrite;
        logic        aluclass;
        logic        illegal;
    } decode_t;

    localparam decode_t DEC_RESET = '{alusel: `ALU_ADD, default: '0};

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'b0};
    endfunction

    // alt selects the funct7=0100000 variant (SUB / SRA) of the funct3 operation.
    function automatic logic [3:0] base_sel(input logic [2:0] funct3, input logic alt);
        logic [3:0] sel;
        case (funct3)
            `RV_F3_ADD:  sel = alt ? `ALU_SUB : `ALU_ADD;
            `RV_F3_SLL:  sel = `ALU_SLL;
            `RV_F3_SLT:  sel = `ALU_SLT;
            `RV_F3_SLTU: sel = `ALU_SLTU;
            `RV_F3_XOR:  sel = `ALU_XOR;
            `RV_F3_SR:   sel = alt ? `ALU_SRA : `ALU_SRL;
            `RV_F3_OR:   sel = `ALU_OR;
            default:     sel = `ALU_AND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Purely combinational RV32I decode into ALU select, operands and writeback controls.
`include "alu_definitions.vh"
`include "rv32i_opcodes.vh"

module alu_decode_comb
    import alu_decode_stage_pkg::*;
(
    input  logic [31:0] I_instr,
    input  logic [31:0] I_pc,
    input  logic [31:0] I_rs1data,
    input  logic [31:0] I_rs2data,
    output decode_t     O_dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_shift;
    logic       f7_base;
    logic       f7_alt;

    assign opcode   = I_instr[6:0];
    assign funct3   = I_instr[14:12];
    assign funct7   = I_instr[31:25];
    assign is_shift = (funct3 == `RV_F3_SLL) || (funct3 == `RV_F3_SR);
    assign f7_base  = (funct7 == `RV_F7_BASE);
    assign f7_alt   = (funct7 == `RV_F7_ALT);

    always_comb begin
        O_dec.alusel   = `ALU_ADD;
        O_dec.data1    = I_rs1data;
        O_dec.data2    = imm_i(I_instr);
        O_dec.rd       = I_instr[11:7];
        O_dec.regwrite = 1'b0;
        O_dec.aluclass = 1'b0;
        O_dec.illegal  = 1'b0;

        case (opcode)
            `RV_OPC_OP: begin
                O_dec.aluclass = 1'b1;
                O_dec.alusel   = base_sel(funct3, f7_alt);
                O_dec.illegal  = !(f7_base || (f7_alt && (funct3 == `RV_F3_ADD || funct3 == `RV_F3_SR)));
                // The ALU shifts by the whole operand, so the amount must be trimmed here.
                O_dec.data2    = is_shift ? {27'b0, I_rs2data[4:0]} : I_rs2data;
            end
            `RV_OPC_OPIMM: begin
                O_dec.aluclass = 1'b1;
                O_dec.alusel   = base_sel(funct3, (funct3 == `RV_F3_SR) && f7_alt);
                O_dec.illegal  = ((funct3 == `RV_F3_SLL) && !f7_base) ||
                                 ((funct3 == `RV_F3_SR) && !f7_base && !f7_alt);
                if (is_shift) begin
                    O_dec.data2 = {27'b0, I_instr[24:20]};
                end
            end
            `RV_OPC_LUI: begin
                O_dec.aluclass = 1'b1;
                O_dec.alusel   = `ALU_LUI;
                O_dec.data1    = 32'b0;
                O_dec.data2    = imm_u(I_instr);
            end
            `RV_OPC_AUIPC: begin
                O_dec.aluclass = 1'b1;
                O_dec.data1    = I_pc;
                O_dec.data2    = imm_u(I_instr);
            end
            default: ;
        endcase

        if (O_dec.illegal) begin
            O_dec.alusel = `ALU_ADD;
        end
        O_dec.regwrite = O_dec.aluclass && !O_dec.illegal && (O_dec.rd != 5'd0);
    end

endmodule

// File: rtl/alu_definitions.vh
// ALU operation select codes shared by the decode stage and the execute ALU.
`ifndef ALU_DEFINITIONS_VH
`define ALU_DEFINITIONS_VH

`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`define ALU_LUI  4'd10

`endif

// File: rtl/rv32i_opcodes.vh
// RV32I opcode, funct3 and funct7 field values shared by decode blocks.
`ifndef RV32I_OPCODES_VH
`define RV32I_OPCODES_VH

`define RV_OPC_OP     7'b0110011
`define RV_OPC_OPIMM  7'b0010011
`define RV_OPC_LUI    7'b0110111
`define RV_OPC_AUIPC  7'b0010111

`define RV_F3_ADD     3'b000
`define RV_F3_SLL     3'b001
`define RV_F3_SLT     3'b010
`define RV_F3_SLTU    3'b011
`define RV_F3_XOR     3'b100
`define RV_F3_SR      3'b101
`define RV_F3_OR      3'b110
`define RV_F3_AND     3'b111

`define RV_F7_BASE    7'b0000000
`define RV_F7_ALT     7'b0100000

`endif

// File: rtl/alu_decode_stage.sv
// Decode pipeline register between fetch and execute with valid/ready handshake and flush.
module alu_decode_stage
    import alu_decode_stage_pkg::*;
(
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [31:0] I_instr,
    input  logic [31:0] I_pc,
    input  logic        I_valid,
    output logic        O_ready,
    output logic [4:0]  O_rs1addr,
    output logic [4:0]  O_rs2addr,
    input  logic [31:0] I_rs1data,
    input  logic [31:0] I_rs2data,
    input  logic        I_ready,
    input  logic        I_flush,
    output logic        O_valid,
    output logic [3:0]  O_alusel,
    output logic [31:0] O_data1,
    output logic [31:0] O_data2,
    output logic [4:0]  O_rd,
    output logic        O_regwrite,
    output logic        O_aluclass,
    output logic        O_illegal
);

    decode_t dec_d;
    decode_t dec_q;
    logic    valid_q;
    logic    load;

    alu_decode_comb u_comb (
        .I_instr   (I_instr),
        .I_pc      (I_pc),
        .I_rs1data (I_rs1data),
        .I_rs2data (I_rs2data),
        .O_dec     (dec_d)
    );

    assign O_ready   = !valid_q || I_ready;
    assign O_rs1addr = I_instr[19:15];
    assign O_rs2addr = I_instr[24:20];
    assign load      = I_valid && O_ready && !I_flush;

    // Flush only kills valid; the data fields are allowed to go stale.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            valid_q <= 1'b0;
            dec_q   <= DEC_RESET;
        end else if (I_flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            dec_q   <= dec_d;
        end else if (I_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign O_valid    = valid_q;
    assign O_alusel   = dec_q.alusel;
    assign O_data1    = dec_q.data1;
    assign O_data2    = dec_q.data2;
    assign O_rd       = dec_q.rd;
    assign O_regwrite = dec_q.regwrite;
    assign O_aluclass = dec_q.aluclass;
    assign O_illegal  = dec_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomized and directed check of alu_decode_stage against a behavioural pipeline model.
`include "alu_definitions.vh"

module tb_alu_decode_stage;

    logic        I_clk = 1'b0;
    logic        I_rst = 1'b0;
    logic [31:0] I_instr = '0;
    logic [31:0] I_pc = '0;
    logic        I_valid = 1'b0;
    logic        O_ready;
    logic [4:0]  O_rs1addr;
    logic [4:0]  O_rs2addr;
    logic [31:0] I_rs1data = '0;
    logic [31:0] I_rs2data = '0;
    logic        I_ready = 1'b1;
    logic        I_flush = 1'b0;
    logic        O_valid;
    logic [3:0]  O_alusel;
    logic [31:0] O_data1;
    logic [31:0] O_data2;
    logic [4:0]  O_rd;
    logic        O_regwrite;
    logic        O_aluclass;
    logic        O_illegal;

    alu_decode_stage dut (
        .I_clk      (I_clk),
        .I_rst      (I_rst),
        .I_instr    (I_instr),
        .I_pc       (I_pc),
        .I_valid    (I_valid),
        .O_ready    (O_ready),
        .O_rs1addr  (O_rs1addr),
        .O_rs2addr  (O_rs2addr),
        .I_rs1data  (I_rs1data),
        .I_rs2data  (I_rs2data),
        .I_ready    (I_ready),
        .I_flush    (I_flush),
        .O_valid    (O_valid),
        .O_alusel   (O_alusel),
        .O_data1    (O_data1),
        .O_data2    (O_data2),
        .O_rd       (O_rd),
        .O_regwrite (O_regwrite),
        .O_aluclass (O_aluclass),
        .O_illegal  (O_illegal)
    );

    always #5 I_clk = ~I_clk;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        rw;
        logic        cls;
        logic        ill;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    logic m_init  = 1'b0;
    logic m_valid = 1'b0;
    exp_t m_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference decode written directly from the instruction-set rules.
    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [3:0] tab [8];
        int op, f3, f7;
        int imm;
        tab[0] = `ALU_ADD; tab[1] = `ALU_SLL; tab[2] = `ALU_SLT; tab[3] = `ALU_SLTU;
        tab[4] = `ALU_XOR; tab[5] = `ALU_SRL; tab[6] = `ALU_OR;  tab[7] = `ALU_AND;
        op  = int'(ins[6:0]);
        f3  = int'(ins[14:12]);
        f7  = int'(ins[31:25]);
        imm = int'($signed(ins[31:20]));
        e.sel = `ALU_ADD; e.d1 = a; e.d2 = imm; e.rd = ins[11:7];
        e.cls = 1'b0; e.ill = 1'b0;
        if (op == 'h33) begin
            e.cls = 1'b1;
            e.d2  = b;
            if (f7 == 0) e.sel = tab[f3];
            else if (f7 == 32 && f3 == 0) e.sel = `ALU_SUB;
            else if (f7 == 32 && f3 == 5) e.sel = `ALU_SRA;
            else e.ill = 1'b1;
            if (f3 == 1 || f3 == 5) e.d2 = b % 32;
        end else if (op == 'h13) begin
            e.cls = 1'b1;
            if (f3 == 1 || f3 == 5) begin
                e.d2 = int'(ins[24:20]);
                if (f7 == 0) e.sel = tab[f3];
                else if (f3 == 5 && f7 == 32) e.sel = `ALU_SRA;
                else e.ill = 1'b1;
            end else begin
                e.sel = tab[f3];
            end
        end else if (op == 'h37) begin
            e.cls = 1'b1; e.sel = `ALU_LUI; e.d1 = 0; e.d2 = ins & 32'hFFFFF000;
        end else if (op == 'h17) begin
            e.cls = 1'b1; e.d1 = pc; e.d2 = ins & 32'hFFFFF000;
        end
        if (e.ill) e.sel = `ALU_ADD;
        e.rw = e.cls && !e.ill && (e.rd != 0);
        return e;
    endfunction

    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic v, input logic rdy, input logic fl,
                        input logic rs);
        logic just_rst;
        logic loaded;
        @(negedge I_clk);
        I_instr = ins; I_pc = pc; I_rs1data = a; I_rs2data = b;
        I_valid = v; I_ready = rdy; I_flush = fl; I_rst = rs;
        #1;
        if (m_init) chk("o_ready", {31'b0, O_ready}, {31'b0, !m_valid || rdy});
        chk("rs1addr", {27'b0, O_rs1addr}, {27'b0, ins[19:15]});
        chk("rs2addr", {27'b0, O_rs2addr}, {27'b0, ins[24:20]});
        just_rst = 1'b0;
        loaded   = 1'b0;
        if (rs) begin
            m_valid = 1'b0; m_init = 1'b1; just_rst = 1'b1;
            m_e = '{sel: `ALU_ADD, d1: 0, d2: 0, rd: 0, rw: 0, cls: 0, ill: 0};
        end else if (fl) begin
            m_valid = 1'b0;
        end else if (v && (!m_valid || rdy)) begin
            m_e = model_decode(ins, pc, a, b); m_valid = 1'b1; loaded = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(posedge I_clk);
        #1;
        if (m_init) chk("o_valid", {31'b0, O_valid}, {31'b0, m_valid});
        if (m_valid || just_rst) begin
            chk("alusel",   {28'b0, O_alusel},   {28'b0, m_e.sel});
            chk("rd",       {27'b0, O_rd},       {27'b0, m_e.rd});
            chk("regwrite", {31'b0, O_regwrite}, {31'b0, m_e.rw});
            chk("aluclass", {31'b0, O_aluclass}, {31'b0, m_e.cls});
            chk("illegal",  {31'b0, O_illegal},  {31'b0, m_e.ill});
            if (!m_e.ill) begin
                chk("data1", O_data1, m_e.d1);
                chk("data2", O_data2, m_e.d2);
            end
        end
        if (loaded)
            $display("txn instr=%08h pc=%08h sel=%0d d1=%08h d2=%08h rd=%0d rw=%0b cls=%0b ill=%0b",
                     ins, pc, O_alusel, O_data1, O_data2, O_rd, O_regwrite, O_aluclass, O_illegal);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  others [6];
        int k, p;
        others[0] = 7'b0000011; others[1] = 7'b0100011; others[2] = 7'b1100011;
        others[3] = 7'b1101111; others[4] = 7'b1100111; others[5] = 7'b1110011;
        r = $urandom;
        k = $urandom_range(0, 9);
        p = $urandom_range(0, 9);
        if (k <= 5) begin
            r[6:0] = (k <= 2) ? 7'b0110011 : 7'b0010011;
            if (p <= 5)      r[31:25] = 7'b0000000;
            else if (p <= 8) r[31:25] = 7'b0100000;
        end else if (k == 6) r[6:0] = 7'b0110111;
        else if (k == 7)     r[6:0] = 7'b0010111;
        else                 r[6:0] = others[$urandom_range(0, 5)];
        return r;
    endfunction

    initial begin
        step(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("reset_ready", {31'b0, O_ready}, 32'd1);

        // Directed cases from the instruction examples.
        step(32'hFFB00093, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("addi_data2", O_data2, 32'hFFFFFFFB);
        chk("addi_rw", {31'b0, O_regwrite}, 32'd1);
        step(32'h4041D113, 32'h4, 32'h80000000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("srai_sel", {28'b0, O_alusel}, {28'b0, `ALU_SRA});
        chk("srai_data2", O_data2, 32'h4);
        step(32'h003110B3, 32'h8, 32'h1, 32'hFFFFFF23, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("sll_data2", O_data2, 32'h3);
        step(32'h123452B7, 32'hC, 32'h55, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lui_data2", O_data2, 32'h12345000);
        chk("lui_sel", {28'b0, O_alusel}, {28'b0, `ALU_LUI});
        step(32'h12345297, 32'h100, 32'h55, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("auipc_data1", O_data1, 32'h100);
        step(32'h02000033, 32'h104, 32'h1, 32'h2, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("mul_illegal", {31'b0, O_illegal}, 32'd1);
        chk("mul_valid", {31'b0, O_valid}, 32'd1);
        step(32'h00100013, 32'h108, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("addi_x0_rw", {31'b0, O_regwrite}, 32'd0);

        // Stall three cycles, then flush while stalled, then reset mid-stream.
        step(32'h123452B7, 32'h10C, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(32'hFFB00093, 32'h110, 32'h7, 32'h9, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("stall_data2", O_data2, 32'h12345000);
        end
        step(32'hFFB00093, 32'h110, 32'h7, 32'h9, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_valid", {31'b0, O_valid}, 32'd0);
        step(32'h0041D113, 32'h114, 32'h3, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(32'h00A00093, 32'h118, 32'h3, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(32'h00A00093, 32'h118, 32'h3, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", {31'b0, O_valid}, 32'd0);

        // Random traffic with occasional stalls, flushes and resets.
        for (int i = 0; i < 400; i++) begin
            step(rand_instr(), $urandom, $urandom, $urandom,
                 ($urandom_range(0, 9) < 8), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered decode stage that turns a 32-bit RV32I instruction word into the operation-select, operand and writeback controls consumed by the combinational ALU. It sits between fetch and execute as one pipeline register with a valid/ready handshake on both sides, plus a flush input. It also drives the register-file read addresses. Opcodes that are not ALU-class pass through marked as non-ALU. Malformed ALU-class encodings are flagged illegal.

## Interface
- No parameters. ALU op encodings come from the shared `alu_definitions.vh` header.
- `I_clk` in 1: clock, rising edge.
- `I_rst` in 1: synchronous, active-high reset.
- `I_instr` in 32: instruction word, qualified by `I_valid`.
- `I_pc` in 32: PC of `I_instr`.
- `I_valid` in 1: upstream has an instruction.
- `O_ready` out 1: stage accepts this cycle; equals `!O_valid || I_ready`.
- `O_rs1addr`, `O_rs2addr` out 5: combinational from `I_instr[19:15]` and `I_instr[24:20]`.
- `I_rs1data`, `I_rs2data` in 32: register-file read data, same cycle as `I_instr`.
- `I_ready` in 1: execute stage accepts.
- `I_flush` in 1: discard the registered and incoming instruction.
- `O_valid` out 1: outputs below are meaningful.
- `O_alusel` out 4: ALU operation select.
- `O_data1`, `O_data2` out 32: ALU operands.
- `O_rd` out 5: destination register.
- `O_regwrite` out 1: write `O_rd` with the ALU result.
- `O_aluclass` out 1: instruction is OP, OP-IMM, LUI or AUIPC.
- `O_illegal` out 1: malformed ALU-class encoding.

## Operation
- Load condition: `I_valid && O_ready && !I_flush`. On load, all outputs register the decode of `I_instr` and `O_valid` is set to 1.
- If `O_valid && I_ready` and there is no load, `O_valid` clears to 0. If `!I_ready`, all outputs hold.
- `I_flush` clears `O_valid` next cycle and overrides both load and hold. Data outputs may keep stale values.
- Immediates:
  - I-type: `sext(instr[31:20])`.
  - U-type: `{instr[31:12], 12'b0}`.
  - SLTIU uses the sign-extended immediate; the ALU compares it unsigned.
- OP (0110011): `data1 = rs1data`, `data2 = rs2data`.
  - funct7 0000000: ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3.
  - funct7 0100000: SUB (funct3 000) or SRA (funct3 101).
- OP-IMM (0010011): `data1 = rs1data`, `data2 = imm`.
  - SLLI requires funct7 0000000.
  - SRLI/SRAI use funct7 0000000 or 0100000.
- Shifts of either form: `data2 = {27'b0, amount[4:0]}`. The ALU shifts by full `data2`, so this masking is mandatory.
- LUI (0110111): `ALU_LUI`, `data2` = U-imm, `data1 = 0`.
- AUIPC (0010111): `ALU_ADD`, `data1 = I_pc`, `data2` = U-imm.
- `O_regwrite = aluclass && !illegal && rd != 0`.
- Any other funct7/funct3 combination under OP or OP-IMM sets `O_illegal = 1`. In that case `O_alusel = ALU_ADD` and `O_regwrite = 0`, but the instruction still presents with `O_valid = 1`.
- Non-ALU opcode: `O_aluclass = 0`, `O_illegal = 0`, `O_regwrite = 0`, `O_alusel = ALU_ADD`. Operands follow the OP-IMM path.

## Timing
- Latency 1: an instruction accepted at edge N appears at outputs after edge N.
- Full throughput: one instruction per cycle while `I_ready` is held high.
- `O_ready` and `O_rsXaddr` are combinational; there is no registered path from `I_instr` to them.
- Reset values: `O_valid = 0`, `O_alusel = ALU_ADD`, every other registered output 0. `O_ready` is 1 while `I_rst` is low and `O_valid = 0`.
- Reset mid-stall drops the held instruction.
- Flush and stall together: flush wins and `O_valid = 0` next cycle.
- Back-to-back transfer: when `O_valid && I_ready && I_valid`, the next instruction replaces the current one in the same edge with no bubble.

## Structure
- ALU select codes: reuse the `alu_definitions.vh` macros; never hardcode them.
- Opcode, funct3 and funct7 constants: a new shared header, `rv32i_opcodes.vh`, also used by future decode blocks.
- Sub-module: a natural one is `alu_decode_comb`, a purely combinational decode. The top level holds the pipeline register and the handshake.

## Test plan
- ADDI x1,x0,-5 (`0xFFB00093`), `I_rs1data = 0`: next cycle `O_valid = 1`, `O_alusel = ALU_ADD`, `O_data2 = 0xFFFFFFFB`, `O_rd = 1`, `O_regwrite = 1`.
- SRAI x2,x3,4 (`0x4041D113`): `O_alusel = ALU_SRA`, `O_data2 = 0x00000004`, `O_illegal = 0`.
- SLL with `I_rs2data = 0xFFFFFF23`: `O_data2 = 0x00000003`.
- LUI x5,0x12345 (`0x123452B7`): `O_alusel = ALU_LUI`, `O_data2 = 0x12345000`, `O_regwrite = 1`. AUIPC with `I_pc = 0x100` and the same immediate: `O_data1 = 0x100`, `O_alusel = ALU_ADD`.
- MUL encoding `0x02000033`: `O_illegal = 1`, `O_regwrite = 0`, `O_valid = 1`. ADDI with rd = x0: `O_regwrite = 0`.
- Stall and flush:
  - Hold `I_ready = 0` for 3 cycles: outputs stable and `O_ready = 0` throughout.
  - Then `I_flush = 1` with `I_valid = 1`: `O_valid = 0` next cycle.
  - Assert reset mid-stream: all outputs return to reset values after one edge.
